// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Write-back arbiter for a register file. Requester A (ALU) and B (MEM)
//   compete for a DEPTH-entry FIFO of {reg, data}. Entries are committed
//   in acceptance order, one per cycle, unless the register-file port is
//   held. A per-register pending mask exposes queued writes so that the
//   read stage can detect hazards.
//
// Ports
//   clk, rst            clock, async active-low reset
//   a_valid/a_reg/a_data/a_ready   requester A write channel
//   b_valid/b_reg/b_data/b_ready   requester B write channel
//   hold                register-file port frozen (no commit)
//   src_reg1/src_reg2   read-port register ids
//   hazard1/hazard2     a queued write targets src_reg1/src_reg2
//   DstReg/DstData/WriteReg  register-file write port (head entry)
//   pending             per-register queued-write mask
//   count               FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [3:0]  a_reg,
    input  logic [15:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [3:0]  b_reg,
    input  logic [15:0] b_data,
    output logic        b_ready,
    input  logic        hold,
    input  logic [3:0]  src_reg1,
    input  logic [3:0]  src_reg2,
    output logic        hazard1,
    output logic        hazard2,
    output logic [3:0]  DstReg,
    output logic [15:0] DstData,
    output logic        WriteReg,
    output logic [15:0] pending,
    output logic [3:0]  count
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    localparam logic       PRIO_A  = 1'b0;
    localparam logic       PRIO_B  = 1'b1;

    logic [3:0]    reg_q  [DEPTH];
    logic [15:0]   data_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [3:0]    count_q, count_d;
    logic          prio_q, prio_d;

    logic          not_full;
    logic          push, pop;
    logic [3:0]    sel_reg;
    logic [15:0]   sel_data;
    logic [15:0]   pend;
    logic [PW-1:0] off;

    // Ready depends only on registered occupancy, so a pop in a full cycle
    // cannot open the queue until the next cycle. Gated by rst so both
    // readies read low while reset is asserted.
    assign not_full = (count_q < DEPTH_C);
    assign a_ready  = rst && not_full && a_valid && (!b_valid || prio_q == PRIO_A);
    assign b_ready  = rst && not_full && b_valid && (!a_valid || prio_q == PRIO_B);

    assign sel_reg  = a_ready ? a_reg  : b_reg;
    assign sel_data = a_ready ? a_data : b_data;

    // Writes to r0 are accepted but dropped entirely.
    assign push = (a_ready || b_ready) && (sel_reg != 4'd0);
    assign pop  = (count_q != 4'd0) && !hold;

    always_comb begin
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 4'd1;
        else if (!push && pop)
            count_d = count_q - 4'd1;
        // Only a contested grant flips priority to the loser.
        prio_d = prio_q;
        if (push && a_valid && b_valid)
            prio_d = a_ready ? PRIO_B : PRIO_A;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= 4'd0;
                data_q[i] <= 16'd0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= 4'd0;
            prio_q  <= PRIO_A;
        end else begin
            if (push) begin
                reg_q[wptr_q]  <= sel_reg;
                data_q[wptr_q] <= sel_data;
            end
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            prio_q  <= prio_d;
        end
    end

    // Entry i is live when its distance from the read pointer (mod DEPTH)
    // is below the occupancy.
    always_comb begin
        pend = 16'd0;
        off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rptr_q;
            if (4'(off) < count_q)
                pend[reg_q[i]] = 1'b1;
        end
        pend[0] = 1'b0;
    end

    assign pending  = pend;
    assign hazard1  = pend[src_reg1];
    assign hazard2  = pend[src_reg2];
    assign count    = count_q;
    assign WriteReg = pop;
    assign DstReg   = (count_q != 4'd0) ? reg_q[rptr_q]  : 4'd0;
    assign DstData  = (count_q != 4'd0) ? data_q[rptr_q] : 16'd0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//   Directed test sequence for regfile_wb_arbiter (DEPTH=4). Inputs change
//   1ns after the rising edge; outputs are checked 1ns later, mid-cycle.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, hold;
    logic [3:0]  a_reg, b_reg, src_reg1, src_reg2;
    logic [15:0] a_data, b_data;
    logic        a_ready, b_ready, hazard1, hazard2, WriteReg;
    logic [3:0]  DstReg, count;
    logic [15:0] DstData, pending;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .hold(hold), .src_reg1(src_reg1), .src_reg2(src_reg2),
        .hazard1(hazard1), .hazard2(hazard2),
        .DstReg(DstReg), .DstData(DstData), .WriteReg(WriteReg),
        .pending(pending), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0;
        a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h1234;
        b_valid = 1'b0; b_reg = 4'd0; b_data = 16'h0;
        src_reg1 = 4'd5; src_reg2 = 4'd6;

        // Reset state
        #2;
        chk("rst_count",    count,    0);
        chk("rst_write",    WriteReg, 0);
        chk("rst_pending",  pending,  0);
        chk("rst_a_ready",  a_ready,  0);
        chk("rst_dstreg",   DstReg,   0);
        a_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();

        // Single write
        a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h1234;
        #1;
        chk("s_a_ready", a_ready, 1);
        chk("s_write0",  WriteReg, 0);
        cyc();
        a_valid = 1'b0;
        #1;
        chk("s_write",   WriteReg, 1);
        chk("s_dstreg",  DstReg,   3);
        chk("s_dstdata", DstData,  16'h1234);
        chk("s_pending", pending,  16'h0008);
        cyc(); #1;
        chk("s_count0",  count,    0);
        chk("s_write_e", WriteReg, 0);
        chk("s_data_e",  DstData,  0);

        // Contention: A first, then B
        a_valid = 1'b1; a_reg = 4'd1; a_data = 16'hAAAA;
        b_valid = 1'b1; b_reg = 4'd2; b_data = 16'hBBBB;
        #1;
        chk("c1_a_ready", a_ready, 1);
        chk("c1_b_ready", b_ready, 0);
        cyc(); #1;
        chk("c2_a_ready", a_ready, 0);
        chk("c2_b_ready", b_ready, 1);
        chk("c2_dstreg",  DstReg,  1);
        chk("c2_dstdata", DstData, 16'hAAAA);
        cyc();
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("c3_dstreg",  DstReg,  2);
        chk("c3_dstdata", DstData, 16'hBBBB);
        chk("c3_write",   WriteReg, 1);
        cyc();
        // Lone B transfer must leave priority with A
        b_valid = 1'b1; b_reg = 4'd4; b_data = 16'h4444;
        #1;
        chk("lb_b_ready", b_ready, 1);
        cyc();
        b_valid = 1'b0;
        #1;
        chk("lb_dstreg", DstReg, 4);
        cyc();
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("prio_a_ready", a_ready, 1);
        chk("prio_b_ready", b_ready, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("prio_count", count, 0);

        // Full queue with hold
        hold = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            a_valid = 1'b1; a_reg = 4'(k); a_data = 16'h0010 + 16'(k);
            #1;
            chk("f_a_ready", a_ready, 1);
            cyc();
        end
        a_reg = 4'd5; a_data = 16'h0015;
        #1;
        chk("f_count4",  count,    4);
        chk("f_a_full",  a_ready,  0);
        chk("f_hold_wr", WriteReg, 0);
        chk("f_pending", pending,  16'h001E);
        hold = 1'b0;
        #1;
        chk("f_pop_nordy", a_ready, 0);
        chk("f_commit1",   DstReg,  1);
        chk("f_wr1",       WriteReg, 1);
        cyc(); #1;
        chk("f_count3",  count,   3);
        chk("f_a_ready5", a_ready, 1);
        chk("f_commit2", DstReg,  2);
        cyc();
        a_valid = 1'b0;
        #1;
        chk("f_count3b", count, 3);
        for (int k = 3; k <= 5; k++) begin
            chk("f_commit_reg",  DstReg,  k);
            chk("f_commit_data", DstData, 16'h0010 + k);
            cyc(); #1;
        end
        chk("f_empty", count, 0);

        // Same-register ordering and hazard
        a_valid = 1'b1; a_reg = 4'd5; a_data = 16'h0001;
        #1;
        chk("h_pre", hazard1, 0);
        cyc();
        a_data = 16'h0002;
        #1;
        chk("h1_haz1", hazard1, 1);
        chk("h1_haz2", hazard2, 0);
        chk("h1_data", DstData, 16'h0001);
        cyc();
        a_valid = 1'b0;
        #1;
        chk("h2_haz1", hazard1, 1);
        chk("h2_data", DstData, 16'h0002);
        chk("h2_wr",   WriteReg, 1);
        cyc(); #1;
        chk("h3_haz1", hazard1, 0);

        // Register 0 write discarded, priority untouched
        a_valid = 1'b1; a_reg = 4'd0; a_data = 16'hFFFF;
        b_valid = 1'b1; b_reg = 4'd7; b_data = 16'h7777;
        #1;
        chk("z_a_ready", a_ready, 1);
        cyc(); #1;
        chk("z_count", count,    0);
        chk("z_write", WriteReg, 0);
        chk("z_pend",  pending,  0);
        chk("z_prio",  a_ready,  1);
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("z_count2", count, 0);

        // Asynchronous reset mid-operation
        hold = 1'b1;
        for (int k = 8; k <= 10; k++) begin
            a_valid = 1'b1; a_reg = 4'(k); a_data = 16'(k);
            cyc();
        end
        a_valid = 1'b0;
        #1;
        chk("r_count3",  count,   3);
        chk("r_pending", pending, 16'h0700);
        #1;
        hold = 1'b0; rst = 1'b0;
        #1;
        chk("r_count0", count,    0);
        chk("r_pend0",  pending,  0);
        chk("r_write0", WriteReg, 0);
        cyc();
        rst = 1'b1;
        cyc(); #1;
        chk("r_after", WriteReg, 0);
        a_valid = 1'b1; a_reg = 4'd11; a_data = 16'h0B0B;
        #1;
        chk("r_first_acc", a_ready, 1);
        cyc();
        a_valid = 1'b0;
        #1;
        chk("r_commit", DstReg, 11);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
